// File: rtl/id_ex_hazard_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register with load-use detection.
// The master drives the ID side; the slave is the pipeline register itself.
interface id_ex_hazard_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        IF_ID_Rs;
  logic [4:0]        IF_ID_Rt;
  logic [4:0]        ID_Rd;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemtoReg;
  logic              ID_ALUSrc;
  logic [3:0]        ID_ALUOp;
  logic [DATA_W-1:0] ID_Data1;
  logic [DATA_W-1:0] ID_Data2;
  logic [DATA_W-1:0] ID_Imm;
  logic              Flush;
  logic              Freeze;

  logic [4:0]        ID_EX_Rs;
  logic [4:0]        ID_EX_Rt;
  logic [4:0]        ID_EX_Rd;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemtoReg;
  logic              ID_EX_ALUSrc;
  logic [3:0]        ID_EX_ALUOp;
  logic [DATA_W-1:0] ID_EX_Data1;
  logic [DATA_W-1:0] ID_EX_Data2;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic              PC_Write;
  logic              IF_ID_Write;
  logic              Hazard;
  logic [CNT_W-1:0]  Bubble_Cnt;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, ID_Rd,
    output ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
    output ID_Data1, ID_Data2, ID_Imm, Flush, Freeze,
    input  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
    input  ID_EX_ALUOp, ID_EX_Data1, ID_EX_Data2, ID_EX_Imm,
    input  PC_Write, IF_ID_Write, Hazard, Bubble_Cnt
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, ID_Rd,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_ALUOp,
    input  ID_Data1, ID_Data2, ID_Imm, Flush, Freeze,
    output ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
    output ID_EX_ALUOp, ID_EX_Data1, ID_EX_Data2, ID_EX_Imm,
    output PC_Write, IF_ID_Write, Hazard, Bubble_Cnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and bubble injection.
// Define LOAD_USE_DETECT_EN to enable hazard detection; otherwise only Flush/Freeze act.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           reset,
  id_ex_hazard_if.slave bus
);

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm;
  } ex_t;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  ex_t              ex_q;
  ex_t              id_d;
  logic [0:0]       state;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             hazard;
  logic             hazard_bubble;

  always_comb begin
    id_d            = '0;
    id_d.rs         = bus.IF_ID_Rs;
    id_d.rt         = bus.IF_ID_Rt;
    id_d.rd         = bus.ID_Rd;
    id_d.reg_write  = bus.ID_RegWrite;
    id_d.mem_read   = bus.ID_MemRead;
    id_d.mem_write  = bus.ID_MemWrite;
    id_d.mem_to_reg = bus.ID_MemtoReg;
    id_d.alu_src    = bus.ID_ALUSrc;
    id_d.alu_op     = bus.ID_ALUOp;
    id_d.data1      = bus.ID_Data1;
    id_d.data2      = bus.ID_Data2;
    id_d.imm        = bus.ID_Imm;
  end

`ifdef LOAD_USE_DETECT_EN
  // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
  assign hazard = ~bus.Freeze & ex_q.mem_read & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == bus.IF_ID_Rs) | (ex_q.rd == bus.IF_ID_Rt));
`else
  logic unused_if_id;
  assign unused_if_id = ^{bus.IF_ID_Rs, bus.IF_ID_Rt};
  assign hazard       = 1'b0;
`endif

  // A redirect refetches anyway, so a simultaneous flush suppresses the stall.
  assign hazard_bubble   = hazard & ~bus.Flush;
  assign bus.Hazard      = hazard;
  assign bus.PC_Write    = ~bus.Freeze & ~hazard_bubble;
  assign bus.IF_ID_Write = ~bus.Freeze & ~hazard_bubble;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all-zero reset doubles as a valid bubble in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q         <= '0;
      state        <= ST_RUN;
      bubble_cnt_q <= '0;
    end else if (!bus.Freeze) begin
      if (bus.Flush || hazard) ex_q <= '0;
      else                     ex_q <= id_d;

      case (state)
        ST_RUN:   if (hazard_bubble) state <= ST_STALL;
        ST_STALL: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase

      if (hazard_bubble && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bus.ID_EX_Rs       = ex_q.rs;
  assign bus.ID_EX_Rt       = ex_q.rt;
  assign bus.ID_EX_Rd       = ex_q.rd;
  assign bus.ID_EX_RegWrite = ex_q.reg_write;
  assign bus.ID_EX_MemRead  = ex_q.mem_read;
  assign bus.ID_EX_MemWrite = ex_q.mem_write;
  assign bus.ID_EX_MemtoReg = ex_q.mem_to_reg;
  assign bus.ID_EX_ALUSrc   = ex_q.alu_src;
  assign bus.ID_EX_ALUOp    = ex_q.alu_op;
  assign bus.ID_EX_Data1    = ex_q.data1;
  assign bus.ID_EX_Data2    = ex_q.data2;
  assign bus.ID_EX_Imm      = ex_q.imm;
  assign bus.Bubble_Cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg: reset, pass-through, flush/freeze and
// (when LOAD_USE_DETECT_EN is defined) load-use stall and counter behaviour.
module tb_id_ex_hazard_reg;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  id_ex_hazard_if #(.DATA_W(32), .CNT_W(16)) bus ();

  id_ex_hazard_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic asrc, input logic [3:0] op,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
    bus.IF_ID_Rs    = rs;
    bus.IF_ID_Rt    = rt;
    bus.ID_Rd       = rd;
    bus.ID_RegWrite = rw;
    bus.ID_MemRead  = mr;
    bus.ID_MemWrite = mw;
    bus.ID_MemtoReg = m2r;
    bus.ID_ALUSrc   = asrc;
    bus.ID_ALUOp    = op;
    bus.ID_Data1    = d1;
    bus.ID_Data2    = d2;
    bus.ID_Imm      = imm;
  endtask

  // lw $8, 4($29)
  task automatic drive_lw8();
    drive_id(5'd29, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0, 32'h4);
  endtask

  // add $9, $8, $10
  task automatic drive_add();
    drive_id(5'd8, 5'd10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 32'hAAAA, 32'h5555, 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.Flush  = 1'b0;
    bus.Freeze = 1'b0;
    drive_id('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #2;
    check("rst_rd",      bus.ID_EX_Rd, 0);
    check("rst_memread", bus.ID_EX_MemRead, 0);
    check("rst_data1",   bus.ID_EX_Data1, 0);
    check("rst_cnt",     bus.Bubble_Cnt, 0);
    check("rst_pcw",     bus.PC_Write, 1);
    check("rst_ifidw",   bus.IF_ID_Write, 1);
    check("rst_hazard",  bus.Hazard, 0);
    reset = 1'b0;

    // Plain pass-through, one-cycle latency
    drive_add();
    tick();
    check("pass_rs",    bus.ID_EX_Rs, 8);
    check("pass_rt",    bus.ID_EX_Rt, 10);
    check("pass_rd",    bus.ID_EX_Rd, 9);
    check("pass_rw",    bus.ID_EX_RegWrite, 1);
    check("pass_aluop", bus.ID_EX_ALUOp, 2);
    check("pass_data1", bus.ID_EX_Data1, 32'hAAAA);
    check("pass_data2", bus.ID_EX_Data2, 32'h5555);

    // Freeze holds the register and drops the upstream enables
    bus.Freeze = 1'b1;
    drive_lw8();
    #1;
    check("frz_pcw", bus.PC_Write, 0);
    tick();
    check("frz_rd",    bus.ID_EX_Rd, 9);
    check("frz_data1", bus.ID_EX_Data1, 32'hAAAA);
    bus.Freeze = 1'b0;

    // Flush loads a bubble
    bus.Flush = 1'b1;
    tick();
    check("fl_rd",    bus.ID_EX_Rd, 0);
    check("fl_rw",    bus.ID_EX_RegWrite, 0);
    check("fl_data1", bus.ID_EX_Data1, 0);
    check("fl_cnt",   bus.Bubble_Cnt, 0);
    bus.Flush = 1'b0;

`ifdef LOAD_USE_DETECT_EN
    // lw $8 then dependent add: one stall, one bubble
    tick();
    check("lu_lw_mr", bus.ID_EX_MemRead, 1);
    check("lu_lw_rd", bus.ID_EX_Rd, 8);
    drive_add();
    #1;
    check("lu_hazard", bus.Hazard, 1);
    check("lu_pcw",    bus.PC_Write, 0);
    check("lu_ifidw",  bus.IF_ID_Write, 0);
    tick();
    check("lu_bub_rd",  bus.ID_EX_Rd, 0);
    check("lu_bub_mr",  bus.ID_EX_MemRead, 0);
    check("lu_cnt",     bus.Bubble_Cnt, 1);
    check("lu_hz_clr",  bus.Hazard, 0);
    check("lu_pcw_clr", bus.PC_Write, 1);
    tick();
    check("lu_add_rs", bus.ID_EX_Rs, 8);
    check("lu_add_rd", bus.ID_EX_Rd, 9);

    // lw $0 then add using $0: never a hazard
    drive_id(5'd29, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0, 32'h4);
    tick();
    drive_id(5'd0, 5'd10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 32'h0, 32'h5555, 32'h0);
    #1;
    check("z_hazard", bus.Hazard, 0);
    check("z_pcw",    bus.PC_Write, 1);
    tick();
    check("z_rd",  bus.ID_EX_Rd, 9);
    check("z_cnt", bus.Bubble_Cnt, 1);

    // Flush together with a hazard: flush bubble, no stall, no count
    drive_lw8();
    tick();
    drive_add();
    bus.Flush = 1'b1;
    #1;
    check("fh_hazard", bus.Hazard, 1);
    check("fh_pcw",    bus.PC_Write, 1);
    check("fh_ifidw",  bus.IF_ID_Write, 1);
    tick();
    bus.Flush = 1'b0;
    check("fh_rd",  bus.ID_EX_Rd, 0);
    check("fh_cnt", bus.Bubble_Cnt, 1);

    // Freeze held for three cycles while stalled
    drive_lw8();
    tick();
    drive_add();
    tick();
    check("fs_cnt0", bus.Bubble_Cnt, 2);
    bus.Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fs_pcw",   bus.PC_Write, 0);
      check("fs_ifidw", bus.IF_ID_Write, 0);
      tick();
      check("fs_rd",  bus.ID_EX_Rd, 0);
      check("fs_cnt", bus.Bubble_Cnt, 2);
    end
    bus.Freeze = 1'b0;
    tick();
    check("fs_add_rs", bus.ID_EX_Rs, 8);
    check("fs_add_rd", bus.ID_EX_Rd, 9);

    // Saturation at all-ones
    force dut.bubble_cnt_q = 16'hFFFF;
    #1;
    release dut.bubble_cnt_q;
    drive_lw8();
    tick();
    drive_add();
    tick();
    check("sat_cnt", bus.Bubble_Cnt, 16'hFFFF);

    // Reset asserted mid-stall acts immediately
    #2;
    reset = 1'b1;
    #1;
    check("rs_cnt",  bus.Bubble_Cnt, 0);
    check("rs_rd",   bus.ID_EX_Rd, 0);
    check("rs_pcw",  bus.PC_Write, 1);
    reset = 1'b0;
    tick();
    check("rs_add_rd", bus.ID_EX_Rd, 9);
`else
    // Without detection the dependent add follows the load directly
    tick();
    check("nd_lw_rd", bus.ID_EX_Rd, 8);
    drive_add();
    #1;
    check("nd_hazard", bus.Hazard, 0);
    check("nd_pcw",    bus.PC_Write, 1);
    check("nd_ifidw",  bus.IF_ID_Write, 1);
    tick();
    check("nd_add_rs", bus.ID_EX_Rs, 8);
    check("nd_add_rd", bus.ID_EX_Rd, 9);
    check("nd_cnt",    bus.Bubble_Cnt, 0);

    // Reset mid-run with live state acts immediately
    #2;
    reset = 1'b1;
    #1;
    check("rs_rd",    bus.ID_EX_Rd, 0);
    check("rs_data1", bus.ID_EX_Data1, 0);
    check("rs_pcw",   bus.PC_Write, 1);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection, sitting between the decode stage and the EX-stage forwarding unit. It captures decoded control, operand data and register specifiers each cycle. It presents the `ID_EX_*` register numbers and write/read flags that forwarding consumes. On a load-use dependence it stalls PC and IF/ID for one cycle and injects a bubble, because forwarding alone cannot cover that case.

## Interface
- `DATA_W`, 32, operand/immediate width
- `CNT_W`, 16, width of the bubble counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `IF_ID_Rs`, `IF_ID_Rt`  in  5  source specifiers of the instruction currently in ID
- `ID_Rd`  in  5  destination already resolved by RegDst (Rt for loads)
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemtoReg`, `ID_ALUSrc`  in  1  decoded control
- `ID_ALUOp`  in  4  ALU operation
- `ID_Data1`, `ID_Data2`, `ID_Imm`  in  DATA_W  register-file reads and extended immediate
- `Flush`  in  1  branch/jump redirect; kill the instruction entering EX
- `Freeze`  in  1  global hold (memory busy)
- `ID_EX_Rs`, `ID_EX_Rt`, `ID_EX_Rd`  out  5  registered specifiers
- `ID_EX_RegWrite`, `ID_EX_MemRead`, `ID_EX_MemWrite`, `ID_EX_MemtoReg`, `ID_EX_ALUSrc`  out  1  registered control
- `ID_EX_ALUOp`  out  4  registered ALU operation
- `ID_EX_Data1`, `ID_EX_Data2`, `ID_EX_Imm`  out  DATA_W  registered operands
- `PC_Write`, `IF_ID_Write`  out  1  upstream enables; 0 = hold
- `Hazard`  out  1  load-use detected this cycle (combinational)
- `Bubble_Cnt`  out  CNT_W  saturating count of load-use bubbles

## Operation
- Hazard condition:
  - `Hazard = ID_EX_MemRead && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs || ID_EX_Rd == IF_ID_Rt)`.
  - Forced 0 while `Freeze`=1.
- Two-state FSM:
  - RUN → STALL on a rising edge with `Hazard`=1 and `Flush`=0.
  - STALL → RUN on the next non-frozen edge.
  - STALL marks that the ID/EX register currently holds a hazard bubble. It is used only for bubble accounting; the FSM never stalls twice for one load.
- Register update per edge, priority in this order:
  - `Freeze`: all registers, FSM and counter hold.
  - `Flush`: load a bubble.
  - `Hazard`: load a bubble.
  - Otherwise: load the ID inputs.
- A bubble is all control outputs 0, `ID_EX_ALUOp`=0, specifiers 0, data 0.
- Upstream enables:
  - `PC_Write = IF_ID_Write = ~Freeze & ~(Hazard & ~Flush)`.
  - Flush wins over a hazard: the redirect refetches, so no hold.
- `Bubble_Cnt` increments by 1 on each edge that loads a hazard bubble. It saturates at all-ones and does not count flush bubbles.
- A bubble has `ID_EX_MemRead`=0, so the hazard self-clears in the STALL cycle and the held instruction advances the following cycle. The loaded value then reaches it through MEM/WB forwarding.

## Timing
- Reset, asynchronous and immediate:
  - FSM = RUN.
  - All `ID_EX_*` outputs = 0, which is itself a bubble.
  - `Bubble_Cnt` = 0.
  - Consequently `Hazard`=0 and `PC_Write`=`IF_ID_Write`=1.
- ID → EX latency: 1 cycle.
- Load-use penalty: exactly 1 cycle per dependent load.
- `Hazard`, `PC_Write` and `IF_ID_Write` are combinational from registered state plus `IF_ID_*` and `Flush`/`Freeze`. They are valid in the same cycle.
- `Freeze` asserted while in STALL: the state is retained and the bubble persists until release.
- `Flush` and `Hazard` in the same cycle: a flush bubble is loaded, the FSM stays RUN, the counter is unchanged and the enables are 1.
- Reset asserted mid-stall: the FSM returns to RUN and a pending bubble count is discarded.

## Configuration
- `LOAD_USE_DETECT_EN`
  - Defined: behaviour as above.
  - Undefined: `Hazard` is tied to 0 and the FSM stays in RUN. `PC_Write`=`IF_ID_Write`=`~Freeze`. `Bubble_Cnt` stays 0. Only `Flush`/`Freeze` affect the register. Software must schedule load delay slots.

## Test plan
- Reset mid-run with nonzero state → all `ID_EX_*`=0, `Bubble_Cnt`=0 and `PC_Write`=1 immediately, without waiting for a clock edge.
- `lw $8` followed by `add $9,$8,$10` → `Hazard`=1 for one cycle and `PC_Write`=`IF_ID_Write`=0 that cycle. The next ID/EX is a bubble, the `add` enters EX one cycle later with `ID_EX_Rs`=8, and `Bubble_Cnt`=1.
- `lw $0` followed by `add $9,$0,$10` → no hazard, no bubble, counter stays 0.
- Load-use hazard with `Flush`=1 in the same cycle → bubble loaded, `PC_Write`=1, `Bubble_Cnt` unchanged.
- `Freeze`=1 for 3 cycles during STALL → all outputs constant and enables 0. After release, the held instruction enters EX one cycle later.
- Build without `LOAD_USE_DETECT_EN`, same `lw`/`add` pair → `add` enters EX immediately after the load and `Hazard` stays 0. With `Bubble_Cnt` forced to all-ones in the enabled build, another hazard leaves it at 0xFFFF.
